// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access stage.
//   mem_state_t : access FSM state encoding
//   F3_*        : RV32I load/store funct3 width/sign codes
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane helper for RV32I loads and stores.
//   funct3_i    : access width/sign
//   addr_lo_i   : byte offset within the word
//   wd_i        : store data (RD2)
//   rdata_i     : raw read word from the bus
//   be_o        : byte enables for the access
//   wdata_o     : lane-replicated store data
//   misalign_o  : misaligned address or illegal funct3
//   rdata_ext_o : selected lane, sign- or zero-extended
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic [31:0] rdata_ext_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o        = '0;
        wdata_o     = '0;
        misalign_o  = 1'b0;
        rdata_ext_o = '0;
        // Move the addressed lane down to bit 0.
        shifted     = rdata_i >> {addr_lo_i, 3'b000};

        case (funct3_i)
            F3_B, F3_BU: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{wd_i[7:0]}};
                rdata_ext_o = funct3_i[2] ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o     = {2{wd_i[15:0]}};
                misalign_o  = addr_lo_i[0];
                rdata_ext_o = funct3_i[2] ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                be_o        = 4'b1111;
                wdata_o     = wd_i;
                misalign_o  = |addr_lo_i;
                rdata_ext_o = rdata_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory stage: drives a req/ack data bus for loads and stores, stalls the
// pipeline while an access is in flight and returns aligned, extended load data.
//   clk_i, rst_ni                 : clock, async active-low reset
//   ValidM_i, MemReadM_i,
//   MemWriteM_i, Funct3M_i,
//   ALUResultM_i, WriteDataM_i    : instruction in the memory stage
//   StallM_o                      : hold upstream registers
//   DoneM_o                       : one-cycle completion pulse
//   ReadDataM_o, MisalignM_o,
//   TimeoutM_o                    : results, valid with DoneM_o
//   mem_req_o .. mem_wdata_o      : registered bus request
//   mem_ack_i, mem_rdata_i        : bus response
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ValidM_i,
    input  logic        MemReadM_i,
    input  logic        MemWriteM_i,
    input  logic [2:0]  Funct3M_i,
    input  logic [31:0] ALUResultM_i,
    input  logic [31:0] WriteDataM_i,
    output logic        StallM_o,
    output logic        DoneM_o,
    output logic [31:0] ReadDataM_o,
    output logic        MisalignM_o,
    output logic        TimeoutM_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [7:0] CntMax = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic        access;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic [31:0] al_rdata;

    assign access = ValidM_i & (MemReadM_i | MemWriteM_i);

    // One aligner serves both directions: live inputs decode the request in IDLE,
    // latched fields extend the read word in BUSY.
    assign sel_funct3  = (state_q == IDLE) ? Funct3M_i : funct3_q;
    assign sel_addr_lo = (state_q == IDLE) ? ALUResultM_i[1:0] : addr_lo_q;

    mem_lane_align u_align (
        .funct3_i    (sel_funct3),
        .addr_lo_i   (sel_addr_lo),
        .wd_i        (WriteDataM_i),
        .rdata_i     (mem_rdata_i),
        .be_o        (al_be),
        .wdata_o     (al_wdata),
        .misalign_o  (al_misalign),
        .rdata_ext_o (al_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        addr_lo_d  = addr_lo_q;
        funct3_d   = funct3_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                if (access) begin
                    cnt_d      = '0;
                    rdata_d    = '0;
                    timeout_d  = 1'b0;
                    misalign_d = 1'b0;
                    if (al_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d   = BUSY;
                        req_d     = 1'b1;
                        we_d      = MemWriteM_i;  // read+write resolves to a store
                        addr_d    = ALUResultM_i[31:2];
                        addr_lo_d = ALUResultM_i[1:0];
                        funct3_d  = Funct3M_i;
                        be_d      = al_be;
                        wdata_d   = al_wdata;
                    end
                end
            end
            BUSY: begin
                // Ack takes priority over an expiring counter.
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) rdata_d = al_rdata;
                end else if (cnt_q == CntMax) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            addr_lo_q  <= '0;
            funct3_q   <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            addr_lo_q  <= addr_lo_d;
            funct3_q   <= funct3_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    // The IDLE term is gated by reset so a still-present instruction cannot
    // hold the pipeline while the stage is being reset.
    assign StallM_o    = (rst_ni & (state_q == IDLE) & access) | (state_q == BUSY);
    assign DoneM_o     = (state_q == DONE);
    assign ReadDataM_o = rdata_q;
    assign MisalignM_o = DoneM_o & misalign_q;
    assign TimeoutM_o  = DoneM_o & timeout_q;

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = {addr_q, 2'b00};
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, write_data;
    logic        stall, done;
    logic [31:0] read_data;
    logic        misalign, timeout;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    // Results of the last do_access call.
    int          r_cyc, r_stalls, r_reqs;
    logic        r_unstable;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic        r_we, r_mis, r_to;

    mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ValidM_i     (valid),
        .MemReadM_i   (mem_read),
        .MemWriteM_i  (mem_write),
        .Funct3M_i    (funct3),
        .ALUResultM_i (alu_result),
        .WriteDataM_i (write_data),
        .StallM_o     (stall),
        .DoneM_o      (done),
        .ReadDataM_o  (read_data),
        .MisalignM_o  (misalign),
        .TimeoutM_o   (timeout),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called at a negedge. ack_wait < 0 means never acknowledge; otherwise ack is
    // raised in BUSY cycle number ack_wait+1.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_wait, input logic [31:0] rdata);
        valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = addr; write_data = wd; mem_rdata = rdata;
        r_cyc = 0; r_stalls = 0; r_reqs = 0; r_unstable = 1'b0;
        r_addr = '0; r_be = '0; r_wdata = '0; r_we = 1'b0;
        while (r_cyc < 100) begin
            #1;
            if (done) break;
            if (stall) r_stalls++;
            if (mem_req) begin
                r_reqs++;
                if (r_reqs == 1) begin
                    r_addr = mem_addr; r_be = mem_be; r_wdata = mem_wdata; r_we = mem_we;
                end else if (mem_addr !== r_addr || mem_be !== r_be ||
                             mem_wdata !== r_wdata || mem_we !== r_we) begin
                    r_unstable = 1'b1;
                end
            end
            mem_ack = mem_req && (ack_wait >= 0) && (r_reqs == ack_wait + 1);
            @(negedge clk);
            r_cyc++;
        end
        if (r_cyc >= 100) check_eq("done_bound", 32'(r_cyc), 32'd0);
        r_rdata = read_data; r_mis = misalign; r_to = timeout;
        mem_ack = 1'b0;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check_eq("back_to_idle", {30'b0, done, stall}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        alu_result = '0; write_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", {26'b0, stall, done, misalign, timeout, mem_req, mem_we}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_be_wdata", {mem_be, mem_wdata[27:0]} | {28'b0, mem_wdata[31:28]}, 32'd0);
        check_eq("rst_rdata", read_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100, zero-wait.
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check_eq("lw_addr", r_addr, 32'h100);
        check_eq("lw_be", {28'b0, r_be}, 32'hF);
        check_eq("lw_stalls", 32'(r_stalls), 32'd2);
        check_eq("lw_cycles", 32'(r_cyc), 32'd2);
        check_eq("lw_rdata", r_rdata, 32'hDEADBEEF);

        // LB / LBU 0x103.
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80AABBCC);
        check_eq("lb_be", {28'b0, r_be}, 32'h8);
        check_eq("lb_addr", r_addr, 32'h100);
        check_eq("lb_rdata", r_rdata, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80AABBCC);
        check_eq("lbu_rdata", r_rdata, 32'h00000080);

        // LH / LHU 0x102.
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80AABBCC);
        check_eq("lh_be", {28'b0, r_be}, 32'hC);
        check_eq("lh_rdata", r_rdata, 32'hFFFF80AA);
        do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80AABBCC);
        check_eq("lhu_rdata", r_rdata, 32'h000080AA);

        // SH 0x202, ack in the 4th BUSY cycle.
        do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'hFFFFFFFF);
        check_eq("sh_addr", r_addr, 32'h200);
        check_eq("sh_be", {28'b0, r_be}, 32'hC);
        check_eq("sh_wdata", r_wdata, 32'hABCDABCD);
        check_eq("sh_we", {31'b0, r_we}, 32'd1);
        check_eq("sh_busy", 32'(r_reqs), 32'd4);
        check_eq("sh_stable", {31'b0, r_unstable}, 32'd0);
        check_eq("sh_cycles", 32'(r_cyc), 32'd5);
        check_eq("sh_rdata", r_rdata, 32'd0);

        // SB 0x101 with read+write both set: store wins.
        do_access(1'b1, 1'b1, 3'b000, 32'h101, 32'h000000EE, 0, 32'h11223344);
        check_eq("sb_be", {28'b0, r_be}, 32'h2);
        check_eq("sb_wdata", r_wdata, 32'hEEEEEEEE);
        check_eq("sb_we", {31'b0, r_we}, 32'd1);
        check_eq("sb_rdata", r_rdata, 32'd0);

        // Misaligned LW 0x101 and illegal funct3.
        do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'hDEADBEEF);
        check_eq("mis_reqs", 32'(r_reqs), 32'd0);
        check_eq("mis_cycles", 32'(r_cyc), 32'd1);
        check_eq("mis_stalls", 32'(r_stalls), 32'd1);
        check_eq("mis_flags", {30'b0, r_mis, r_to}, 32'h2);
        check_eq("mis_rdata", r_rdata, 32'd0);
        do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check_eq("ill_flags", {30'b0, r_mis, r_to}, 32'h2);
        check_eq("ill_reqs", 32'(r_reqs), 32'd0);

        // Timeout, then a stray ack.
        do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, -1, 32'hDEADBEEF);
        check_eq("to_reqs", 32'(r_reqs), 32'd16);
        check_eq("to_cycles", 32'(r_cyc), 32'd17);
        check_eq("to_flags", {30'b0, r_mis, r_to}, 32'h1);
        check_eq("to_rdata", r_rdata, 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check_eq("stray_ack", {29'b0, mem_req, done, stall}, 32'd0);
        @(negedge clk);
        check_eq("stray_ack2", {29'b0, mem_req, done, stall}, 32'd0);

        // Reset during BUSY.
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h400;
        @(negedge clk);
        check_eq("pre_rst_req", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", {29'b0, mem_req, stall, done}, 32'd0);
        valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 32'hCAFEF00D);
        check_eq("post_rst_rdata", r_rdata, 32'hCAFEF00D);
        check_eq("post_rst_cycles", 32'(r_cyc), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage that sits directly downstream of the execute stage. It takes the execute stage's ALU result as the effective address and its forwarded RD2 value as store data. It performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a request/acknowledge data-memory bus. While an access is in flight it stalls the pipeline, and it returns load data already aligned and extended for writeback.

## Interface
- TIMEOUT_CYCLES, 16: number of BUSY cycles without an ack before the access is abandoned; legal range 2..255.
- clk_i  in  1  single clock; all state changes on the rising edge
- rst_ni  in  1  asynchronous, active-low reset
- ValidM_i  in  1  instruction present in the memory stage
- MemReadM_i  in  1  load
- MemWriteM_i  in  1  store
- Funct3M_i  in  3  access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ALUResultM_i  in  32  effective byte address
- WriteDataM_i  in  32  store data (RD2)
- StallM_o  out  1  hold upstream registers and this stage's inputs
- DoneM_o  out  1  one-cycle pulse: access finished, results valid
- ReadDataM_o  out  32  extended load data, valid while DoneM_o=1
- MisalignM_o  out  1  with DoneM_o: misaligned address or illegal funct3
- TimeoutM_o  out  1  with DoneM_o: no ack within TIMEOUT_CYCLES
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word address, with [1:0] forced to 00
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_ack_i  in  1  bus acknowledge; completes the transfer
- mem_rdata_i  in  32  read word, sampled with mem_ack_i

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - An access is ValidM_i & (MemReadM_i | MemWriteM_i).
  - If both read and write are set, the access is a store.
  - On an aligned, legal access: StallM_o=1 combinationally; latch addr/be/wdata/we/funct3; go to BUSY.
  - On a misaligned access (H with addr[0]=1, W with addr[1:0]≠00) or funct3 ∈ {011,110,111}: StallM_o=1; latch the error; go to DONE with no bus access.
  - A non-memory or invalid instruction gives StallM_o=0 and the FSM stays in IDLE.
- **BUSY**
  - mem_req_o=1; all bus outputs are held stable from the registers; StallM_o=1; the timeout counter increments.
  - mem_ack_i=1: capture the extended mem_rdata_i and go to DONE.
  - Counter reaches TIMEOUT_CYCLES−1 with no ack: drop the request, set the timeout flag, go to DONE.
  - If ack and timeout fall in the same cycle, the ack wins.
- **DONE**
  - DoneM_o=1 and StallM_o=0.
  - Error flags are valid; ReadDataM_o=0 on error or on a store.
  - Always returns to IDLE. The inputs are not sampled in DONE, because they still carry the same instruction.
- **Byte lanes**
  - Loads and stores use the same byte enables:
    - B: be = 0001 << addr[1:0]
    - H: 0011 or 1100, selected by addr[1]
    - W: 1111
  - Store data: B = {4{wd[7:0]}}, H = {2{wd[15:0]}}, W = wd.
  - Load extract uses lane addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- mem_ack_i arriving in IDLE or DONE (a late or stray ack) is ignored.

## Timing
- Reset values: every output is 0, state is IDLE, the counter and all latched fields are 0.
- Asserting rst_ni mid-access drops mem_req_o immediately and discards the access.
- mem_req_o and mem_* come from registers; StallM_o and DoneM_o are decoded from state plus the IDLE inputs.
- Accept in cycle T → mem_req_o high from T+1.
- Ack in cycle T+k (k≥1) → DoneM_o in T+k+1.
- Zero-wait memory: 3 cycles total, stall for 2.
- Error path: accept in T, DoneM_o in T+1, 1 stall cycle.
- Timeout: DoneM_o with TimeoutM_o in T+TIMEOUT_CYCLES+1.
- Back-to-back accesses: the earliest next accept is the cycle after DONE.

## Structure
- Package mem_pkg holds:
  - mem_state_t enum {IDLE, BUSY, DONE}
  - F3_B, F3_H, F3_W, F3_BU, F3_HU constants
- Sub-module mem_lane_align is combinational and does two jobs:
  - funct3 + addr[1:0] + wd → be, replicated wdata, misalign flag
  - funct3 + addr[1:0] + rdata → extended load data
- The FSM, the latches and the timeout counter live in mem_access_stage.

## Test plan
- LW at 0x100, memory acks in the first BUSY cycle with 0xDEADBEEF:
  - mem_addr_o=0x100, be=1111.
  - Stall is high for 2 cycles; DoneM_o in cycle 3 with ReadDataM_o=0xDEADBEEF.
- LB at 0x103, rdata 0x80AABBCC:
  - be=1000, ReadDataM_o=0xFFFFFF80.
  - Repeat as LBU → 0x00000080.
- SH at 0x202 with data 0x1234ABCD, ack delayed 3 cycles:
  - addr 0x200, be=1100, wdata=0xABCDABCD, we=1.
  - Bus outputs stay stable for 4 BUSY cycles; DoneM_o comes 1 cycle after the ack.
- LW at 0x101:
  - No mem_req_o.
  - DoneM_o and MisalignM_o in the next cycle; ReadDataM_o=0.
- LW with the ack never given (TIMEOUT_CYCLES=16):
  - mem_req_o stays high for exactly 16 cycles, then drops.
  - DoneM_o with TimeoutM_o follows.
  - A stray ack 2 cycles later has no effect.
- rst_ni pulsed low during BUSY:
  - mem_req_o, StallM_o and DoneM_o go to 0 immediately.
  - After release, a fresh LW completes normally.
